// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg: shared types, defaults and helpers for the DAC frame scheduler
package dac_sched_pkg;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } state_t;

    localparam logic [15:0] MIDSCALE_DEFAULT = 16'h8000;
    localparam logic [15:0] CNT_MAX          = 16'hFFFF;

    // The serializer needs DW+1 cycles per frame, so shorter periods are clamped
    function automatic logic [31:0] MIN_DIV(input logic [31:0] rate_div, input int dw);
        return (rate_div < 32'(dw + 1)) ? 32'(dw + 1) : rate_div;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after the last grant
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last_grant,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gnt_idx
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] idx;
    logic          found;

    // Walk the requesters from last_grant+1 around to last_grant; first hit wins
    always_comb begin
        gnt     = '0;
        gnt_idx = last_grant;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_grant) + k) % NREQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = 3'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler: paces frames and sources samples for the serial DAC
module dac_frame_scheduler
    import dac_sched_pkg::*;
#(
    parameter int            NREQ     = 2,
    parameter int            DW       = 16,
    parameter int            DIV_W    = 16,
    parameter logic [DW-1:0] MIDSCALE = DW'(MIDSCALE_DEFAULT)
) (
    input  logic               aclk,
    input  logic               areset_n,
    input  logic               en,
    input  logic [DIV_W-1:0]   rate_div,
    input  logic               mute,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               dac_busy,
    output logic               dac_load,
    output logic [DW-1:0]      dac_data,
    output logic [2:0]         grant_id,
    output logic               underrun,
    output logic               overrun,
    output logic [15:0]        underrun_cnt,
    output logic [15:0]        overrun_cnt
);

    state_t           state, state_nx;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] eff_div;
    logic             tick, busy_tick, mute_tick, take, starve;
    logic [NREQ-1:0]  gnt;
    logic [2:0]       gnt_idx;

    assign eff_div = DIV_W'(MIN_DIV(32'(rate_div), DW));

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .last_grant (grant_id),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    // State register
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) state <= OFF;
        else           state <= state_nx;
    end

    // Next state and per-tick frame decision; busy beats mute beats data beats underrun
    always_comb begin
        state_nx  = en ? RUN : OFF;
        tick      = (state == RUN) && (cnt >= eff_div);
        busy_tick = tick && dac_busy;
        mute_tick = tick && !dac_busy && mute;
        take      = tick && !dac_busy && !mute && (|req_valid);
        starve    = tick && !dac_busy && !mute && !(|req_valid);
        req_ready = take ? gnt : '0;
    end

    // Rate divider: >= compare so a shrinking rate_div cannot skip the wrap
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) cnt <= '0;
        else           cnt <= (state == RUN && en && !tick) ? cnt + DIV_W'(1) : '0;
    end

    // Frame outputs land one cycle after the tick; underrun repeats the last sample
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            dac_load     <= 1'b0;
            dac_data     <= MIDSCALE;
            grant_id     <= 3'(NREQ - 1);
            underrun     <= 1'b0;
            overrun      <= 1'b0;
            underrun_cnt <= '0;
            overrun_cnt  <= '0;
        end else begin
            dac_load     <= mute_tick || take || starve;
            dac_data     <= mute_tick ? MIDSCALE : take ? req_data[int'(gnt_idx)*DW +: DW] : dac_data;
            grant_id     <= take ? gnt_idx : grant_id;
            underrun     <= starve;
            overrun      <= busy_tick;
            underrun_cnt <= starve ? sat_inc(underrun_cnt) : underrun_cnt;
            overrun_cnt  <= busy_tick ? sat_inc(overrun_cnt) : overrun_cnt;
        end
    end

endmodule
